// File: rtl/upe_unsign32.sv
// Sequential sign/magnitude extractor: splits a two's-complement word (one 32-bit lane or two
// 16-bit lanes) into magnitude and sign, negating CHUNK bits per cycle through a registered carry.
module upe_unsign32 #(
  parameter int unsigned CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] In,
  input  logic        split,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Out,
  output logic        sign1,
  output logic        sign2
);

  localparam int unsigned N    = 32 / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned Half = N / 2;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       op_q, op_d;
  logic [31:0]       out_q, out_d;
  logic              split_q, split_d;
  logic              sign1_q, sign1_d;
  logic              sign2_q, sign2_d;
  logic              carry_q, carry_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              lane_sign;
  logic              carry_in;
  logic [CHUNK:0]    sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      out_q   <= '0;
      split_q <= 1'b0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      out_q   <= out_d;
      split_q <= split_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Chunk cnt sits at op_q[CHUNK-1:0]: the operand is shifted right as chunks are consumed.
  always_comb begin
    lane_sign = (cnt_q >= CntW'(Half)) ? sign1_q : (split_q ? sign2_q : sign1_q);
    // In split mode the upper lane starts its own negation instead of taking the low carry.
    carry_in  = (split_q && (cnt_q == CntW'(Half))) ? sign1_q : carry_q;
    sum       = {1'b0, op_q[CHUNK-1:0] ^ {CHUNK{lane_sign}}} + {{CHUNK{1'b0}}, carry_in};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    out_d   = out_q;
    split_d = split_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = In;
          split_d = split;
          sign1_d = In[31];
          sign2_d = split & In[15];
          carry_d = split ? In[15] : In[31];
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        op_d    = op_q >> CHUNK;
        // Result chunks enter from the top so that after N shifts chunk 0 lands at bit 0.
        out_d   = {sum[CHUNK-1:0], out_q[31:CHUNK]};
        carry_d = sum[CHUNK];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign Out       = out_q;
  assign sign1     = sign1_q;
  assign sign2     = sign2_q;

endmodule

// File: tb/tb_upe_unsign32.sv
// Bench for upe_unsign32: three instances (CHUNK = 4, 8, 16) checked against an arithmetic
// sign/magnitude model, with directed edge cases, backpressure and mid-operation reset.
module tb_upe_unsign32;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_w;
  logic        split;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [31:0] outs [3];
  logic [2:0]  sign1;
  logic [2:0]  sign2;

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned C = (g == 0) ? 4 : ((g == 1) ? 8 : 16);
    upe_unsign32 #(.CHUNK(C)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .In       (in_w),
      .split    (split),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .Out      (outs[g]),
      .sign1    (sign1[g]),
      .sign2    (sign2[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] abs16(input logic [15:0] x);
    return x[15] ? 16'(16'd0 - x) : x;
  endfunction

  function automatic logic [31:0] mag_of(input logic [31:0] v, input logic sp);
    if (!sp) return v[31] ? (32'd0 - v) : v;
    return {abs16(v[31:16]), abs16(v[15:0])};
  endfunction

  function automatic logic [31:0] resign(input logic [31:0] m, input logic s1, input logic s2,
                                         input logic sp);
    logic [15:0] hi, lo;
    if (!sp) return s1 ? (32'd0 - m) : m;
    hi = m[31:16];
    lo = m[15:0];
    return {s1 ? 16'(16'd0 - hi) : hi, s2 ? 16'(16'd0 - lo) : lo};
  endfunction

  // Waits (bounded) for out_valid on instance d; entered just after the accept edge's negedge.
  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (!out_valid[d] && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input int d, input logic [31:0] v, input logic sp);
    chk("out", outs[d], mag_of(v, sp));
    chk("sign1", 32'(sign1[d]), 32'(v[31]));
    chk("sign2", 32'(sign2[d]), 32'(sp & v[15]));
    chk("roundtrip", resign(outs[d], sign1[d], sign2[d], sp), v);
  endtask

  // Full transaction with out_ready high; starts and ends at a negedge.
  task automatic run_op(input int d, input logic [31:0] v, input logic sp);
    int lat;
    int n_exp;
    n_exp = 32 / (4 << d);
    in_w = v;
    split = sp;
    in_valid[d] = 1'b1;
    out_ready[d] = 1'b1;
    chk("in_ready_idle", 32'(in_ready[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_w = $urandom;
    split = 1'($urandom_range(0, 1));
    wait_done(d, lat);
    chk("latency", 32'(lat), 32'(n_exp));
    check_result(d, v, sp);
    chk("in_ready_done", 32'(in_ready[d]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("out_valid_drop", 32'(out_valid[d]), 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] v;
    logic [31:0] special [6];
    n_cmp = 0;
    n_bad = 0;
    special[0] = 32'h0000_0000;
    special[1] = 32'h8000_0000;
    special[2] = 32'h8000_8000;
    special[3] = 32'hFFFF_FFFF;
    special[4] = 32'h0000_8000;
    special[5] = 32'hFFFF_0000;
    rst_n = 1'b0;
    in_w = '0;
    split = 1'b0;
    in_valid = '0;
    out_ready = '0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
      chk("rst_out", outs[d], 32'd0);
      chk("rst_signs", 32'({sign1[d], sign2[d]}), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases on the CHUNK=8 instance.
    run_op(1, 32'hFFFF_FFFB, 1'b0);
    run_op(1, 32'h0000_007F, 1'b0);
    run_op(1, 32'hFFFF_FF00, 1'b0);
    run_op(1, 32'h8000_0000, 1'b0);
    run_op(1, 32'h0000_0000, 1'b0);
    run_op(1, 32'hFFFF_8000, 1'b1);
    run_op(1, 32'h7FFF_FFFE, 1'b1);
    for (int d = 0; d < 3; d += 2) begin
      run_op(d, 32'hFFFF_8000, 1'b1);
      run_op(d, 32'hFFFF_FF00, 1'b0);
    end

    // Backpressure: DONE held for 10 cycles while in_valid stays high with changing In.
    in_w = 32'h1234_5678;
    split = 1'b0;
    in_valid[1] = 1'b1;
    out_ready[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_w = 32'hFFFF_FFFF;
    wait_done(1, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      in_w = $urandom;
      split = 1'($urandom_range(0, 1));
      chk("bp_out_valid", 32'(out_valid[1]), 32'd1);
      chk("bp_in_ready", 32'(in_ready[1]), 32'd0);
      check_result(1, 32'h1234_5678, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    in_w = 32'hAAAA_5555;
    split = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_idle", 32'(in_ready[1]), 32'd1);
    chk("bp_release_valid", 32'(out_valid[1]), 32'd0);
    in_w = 32'hFFFF_FFF0;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    wait_done(1, lat);
    chk("bp_next_latency", 32'(lat), 32'd4);
    check_result(1, 32'hFFFF_FFF0, 1'b0);
    @(posedge clk);
    @(negedge clk);

    // Reset in BUSY cycle 2: no result may appear and everything returns to reset values.
    in_w = 32'h0000_1234;
    split = 1'b0;
    in_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    chk("abort_busy1", 32'(out_valid[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy2", 32'(out_valid[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid[1]), 32'd0);
    chk("abort_in_ready", 32'(in_ready[1]), 32'd1);
    chk("abort_out", outs[1], 32'd0);
    chk("abort_signs", 32'({sign1[1], sign2[1]}), 32'd0);
    @(negedge clk);
    chk("abort_hold", 32'(out_valid[1]), 32'd0);
    rst_n = 1'b1;
    run_op(1, 32'h0000_0005, 1'b0);

    // Random back-to-back traffic on every CHUNK width.
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 1000; i++) begin
        v = (($urandom_range(0, 7)) == 0) ? special[$urandom_range(0, 5)] : $urandom;
        run_op(d, v, 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
